// File: rtl/cursor_select_ctrl.sv
// Board-cursor and piece-selection controller feeding the VGA board renderer.
// Turns single-cycle button pulses into cursor / selection state and issues
// from/to move requests to the game-logic stage over a valid/ready handshake.
// Square address = {row[2:0], col[2:0]}; row 0 is the top, col 0 the left.
module cursor_select_ctrl #(
  parameter logic [5:0] RESET_CURSOR = 6'd60,
  parameter bit         WRAP         = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_left,
  input  logic         btn_right,
  input  logic         btn_center,
  input  logic         btn_cancel,
  input  logic [255:0] board,
  input  logic         turn,
  input  logic         move_ready,
  output logic [5:0]   cursor_address,
  output logic [5:0]   selected_address,
  output logic         selected_enable,
  output logic         move_valid,
  output logic [5:0]   move_from,
  output logic [5:0]   move_to
);

  typedef enum logic [1:0] {S_IDLE, S_SELECTED, S_REQUEST} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_cursor;
  logic [5:0]  r_sel_addr;
  logic        r_sel_en;
  logic        r_move_valid;
  logic [5:0]  r_move_from;
  logic [5:0]  r_move_to;

  logic [5:0]  w_cursor_nxt;
  logic [5:0]  w_sel_addr_nxt;
  logic        w_sel_en_nxt;
  logic        w_move_valid_nxt;
  logic [5:0]  w_move_from_nxt;
  logic [5:0]  w_move_to_nxt;

  logic        w_cur_own;
  logic        w_sel_own;
  logic [2:0]  w_dir_cnt;
  logic        w_dir_move;
  logic [2:0]  w_row;
  logic [2:0]  w_col;
  logic        w_center;
  logic        w_cancel;

  // A square holds an own piece when it is occupied and its colour matches turn.
  function automatic logic own_piece(input logic [255:0] b, input logic [5:0] s,
                                     input logic t);
    logic [3:0] sq;
    sq = b[{s, 2'b00} +: 4];
    return (sq[2:0] != 3'd0) && (sq[3] == t);
  endfunction

  // Decrement a row/col coordinate, wrapping or holding at 0.
  function automatic logic [2:0] step_dec(input logic [2:0] v);
    if (v == 3'd0) return WRAP ? 3'd7 : 3'd0;
    return v - 3'd1;
  endfunction

  // Increment a row/col coordinate, wrapping or holding at 7.
  function automatic logic [2:0] step_inc(input logic [2:0] v);
    if (v == 3'd7) return WRAP ? 3'd0 : 3'd7;
    return v + 3'd1;
  endfunction

  assign w_cur_own  = own_piece(board, r_cursor, turn);
  assign w_sel_own  = own_piece(board, r_sel_addr, turn);
  assign w_dir_cnt  = {2'b00, btn_up} + {2'b00, btn_down} + {2'b00, btn_left} + {2'b00, btn_right};
  // Cancel outranks center, center outranks directions; REQUEST ignores all buttons.
  assign w_cancel   = btn_cancel && (r_state != S_REQUEST);
  assign w_center   = btn_center && !btn_cancel && (r_state != S_REQUEST);
  assign w_dir_move = (w_dir_cnt == 3'd1) && !btn_cancel && !btn_center && (r_state != S_REQUEST);
  assign w_row      = r_cursor[5:3];
  assign w_col      = r_cursor[2:0];

  // State and output registers; everything the renderer sees is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cursor     <= RESET_CURSOR;
      r_sel_addr   <= 6'd0;
      r_sel_en     <= 1'b0;
      r_move_valid <= 1'b0;
      r_move_from  <= 6'd0;
      r_move_to    <= 6'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_cursor     <= w_cursor_nxt;
      r_sel_addr   <= w_sel_addr_nxt;
      r_sel_en     <= w_sel_en_nxt;
      r_move_valid <= w_move_valid_nxt;
      r_move_from  <= w_move_from_nxt;
      r_move_to    <= w_move_to_nxt;
    end
  end

  // Next-state: selection, deselection, request issue, stale drop and handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_center && w_cur_own) w_state_nxt = S_SELECTED;
      end
      S_SELECTED: begin
        if (w_cancel)                      w_state_nxt = S_IDLE;
        else if (w_center) begin
          if (r_cursor == r_sel_addr)      w_state_nxt = S_IDLE;
          else if (w_cur_own)              w_state_nxt = S_SELECTED;
          else                             w_state_nxt = S_REQUEST;
        end else if (!w_sel_own)           w_state_nxt = S_IDLE;
      end
      S_REQUEST: begin
        if (r_move_valid && move_ready)    w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output next values, derived from the current state and the chosen transition.
  always_comb begin
    w_cursor_nxt     = r_cursor;
    w_sel_addr_nxt   = r_sel_addr;
    w_move_from_nxt  = r_move_from;
    w_move_to_nxt    = r_move_to;
    w_sel_en_nxt     = (w_state_nxt != S_IDLE);
    w_move_valid_nxt = (w_state_nxt == S_REQUEST);

    if (w_dir_move) begin
      if (btn_up)         w_cursor_nxt = {step_dec(w_row), w_col};
      else if (btn_down)  w_cursor_nxt = {step_inc(w_row), w_col};
      else if (btn_left)  w_cursor_nxt = {w_row, step_dec(w_col)};
      else                w_cursor_nxt = {w_row, step_inc(w_col)};
    end

    // Center landing in SELECTED (from IDLE, or onto another own piece) moves the selection.
    if (w_center && (w_state_nxt == S_SELECTED))
      w_sel_addr_nxt = r_cursor;

    // Request payload is captured once on entry and then held until the handshake.
    if ((r_state == S_SELECTED) && (w_state_nxt == S_REQUEST)) begin
      w_move_from_nxt = r_sel_addr;
      w_move_to_nxt   = r_cursor;
    end
  end

  assign cursor_address   = r_cursor;
  assign selected_address = r_sel_addr;
  assign selected_enable  = r_sel_en;
  assign move_valid       = r_move_valid;
  assign move_from        = r_move_from;
  assign move_to          = r_move_to;

endmodule

// File: tb/tb_cursor_select_ctrl.sv
// Directed bench for cursor_select_ctrl: a wrapping and a saturating instance
// share the same stimulus; expected values are hand-computed per scenario.
module tb_cursor_select_ctrl;

  localparam logic [5:0] B_CANCEL = 6'b100000;
  localparam logic [5:0] B_CENTER = 6'b010000;
  localparam logic [5:0] B_UP     = 6'b001000;
  localparam logic [5:0] B_DOWN   = 6'b000100;
  localparam logic [5:0] B_LEFT   = 6'b000010;
  localparam logic [5:0] B_RIGHT  = 6'b000001;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic         btn_center = 1'b0, btn_cancel = 1'b0;
  logic [255:0] board;
  logic         turn = 1'b0;
  logic         move_ready = 1'b0;

  logic [5:0] cur_w, sel_w, from_w, to_w;
  logic       en_w, vld_w;
  logic [5:0] cur_s, sel_s, from_s, to_s;
  logic       en_s, vld_s;

  int n_pass  = 0;
  int n_total = 0;

  cursor_select_ctrl #(.RESET_CURSOR(6'd60), .WRAP(1'b1)) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_center(btn_center), .btn_cancel(btn_cancel),
    .board(board), .turn(turn), .move_ready(move_ready),
    .cursor_address(cur_w), .selected_address(sel_w), .selected_enable(en_w),
    .move_valid(vld_w), .move_from(from_w), .move_to(to_w)
  );

  cursor_select_ctrl #(.RESET_CURSOR(6'd60), .WRAP(1'b0)) dut_sat (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_center(btn_center), .btn_cancel(btn_cancel),
    .board(board), .turn(turn), .move_ready(move_ready),
    .cursor_address(cur_s), .selected_address(sel_s), .selected_enable(en_s),
    .move_valid(vld_s), .move_from(from_s), .move_to(to_s)
  );

  always #5 clk = ~clk;

  // Standard start position: black on rows 0-1, white on rows 6-7.
  task automatic load_start_board();
    logic [2:0] back [8];
    back[0] = 3'd4; back[1] = 3'd2; back[2] = 3'd3; back[3] = 3'd5;
    back[4] = 3'd6; back[5] = 3'd3; back[6] = 3'd2; back[7] = 3'd4;
    board = '0;
    for (int c = 0; c < 8; c++) begin
      board[4*(0*8+c) +: 4] = {1'b1, back[c]};
      board[4*(1*8+c) +: 4] = {1'b1, 3'd1};
      board[4*(6*8+c) +: 4] = {1'b0, 3'd1};
      board[4*(7*8+c) +: 4] = {1'b0, back[c]};
    end
  endtask

  // One-cycle button pulse; returns at the falling edge after it was sampled.
  task automatic press(input logic [5:0] b);
    @(negedge clk);
    {btn_cancel, btn_center, btn_up, btn_down, btn_left, btn_right} = b;
    @(negedge clk);
    {btn_cancel, btn_center, btn_up, btn_down, btn_left, btn_right} = 6'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (cur_w !== 6'd60) $display("FAIL reset_cursor got %0d want 60", cur_w); else n_pass++;
    n_total++; if (sel_w !== 6'd0) $display("FAIL reset_sel got %0d want 0", sel_w); else n_pass++;
    n_total++; if (en_w !== 1'b0) $display("FAIL reset_en got %0b want 0", en_w); else n_pass++;
    n_total++; if (vld_w !== 1'b0) $display("FAIL reset_valid got %0b want 0", vld_w); else n_pass++;
    n_total++; if (from_w !== 6'd0) $display("FAIL reset_from got %0d want 0", from_w); else n_pass++;
    n_total++; if (to_w !== 6'd0) $display("FAIL reset_to got %0d want 0", to_w); else n_pass++;
  endtask

  task automatic test_cursor();
    logic [5:0] exp_up [3];
    exp_up[0] = 6'd52; exp_up[1] = 6'd44; exp_up[2] = 6'd36;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      press(B_UP);
      n_total++; if (cur_w !== exp_up[i]) $display("FAIL cursor_up%0d got %0d want %0d", i, cur_w, exp_up[i]); else n_pass++;
    end
    for (int i = 0; i < 4; i++) press(B_LEFT);
    n_total++; if (cur_w !== 6'd32) $display("FAIL cursor_left_to_col0 got %0d want 32", cur_w); else n_pass++;
    press(B_LEFT);
    n_total++; if (cur_w !== 6'd39) $display("FAIL cursor_wrap_left got %0d want 39", cur_w); else n_pass++;
    n_total++; if (cur_s !== 6'd32) $display("FAIL cursor_sat_left got %0d want 32", cur_s); else n_pass++;
    press(B_RIGHT);
    n_total++; if (cur_w !== 6'd32) $display("FAIL cursor_wrap_right got %0d want 32", cur_w); else n_pass++;
    n_total++; if (cur_s !== 6'd33) $display("FAIL cursor_sat_right got %0d want 33", cur_s); else n_pass++;
    press(B_UP | B_LEFT);
    n_total++; if (cur_w !== 6'd32) $display("FAIL cursor_two_dirs got %0d want 32", cur_w); else n_pass++;
    for (int i = 0; i < 4; i++) press(B_UP);
    n_total++; if (cur_s !== 6'd1) $display("FAIL cursor_sat_top got %0d want 1", cur_s); else n_pass++;
    n_total++; if (cur_w !== 6'd0) $display("FAIL cursor_wrap_to_row0 got %0d want 0", cur_w); else n_pass++;
    press(B_UP);
    n_total++; if (cur_w !== 6'd56) $display("FAIL cursor_wrap_up got %0d want 56", cur_w); else n_pass++;
  endtask

  task automatic test_move_request();
    do_reset();
    press(B_UP);
    press(B_CENTER);
    n_total++; if (en_w !== 1'b1) $display("FAIL sel_en got %0b want 1", en_w); else n_pass++;
    n_total++; if (sel_w !== 6'd52) $display("FAIL sel_addr got %0d want 52", sel_w); else n_pass++;
    press(B_UP);
    press(B_UP);
    press(B_CENTER);
    n_total++; if (vld_w !== 1'b1) $display("FAIL req_valid got %0b want 1", vld_w); else n_pass++;
    n_total++; if (from_w !== 6'd52) $display("FAIL req_from got %0d want 52", from_w); else n_pass++;
    n_total++; if (to_w !== 6'd36) $display("FAIL req_to got %0d want 36", to_w); else n_pass++;
    press(B_UP);
    n_total++; if (cur_w !== 6'd36) $display("FAIL req_cursor_frozen got %0d want 36", cur_w); else n_pass++;
    n_total++; if (vld_w !== 1'b1) $display("FAIL req_hold1 got %0b want 1", vld_w); else n_pass++;
    press(B_CANCEL);
    n_total++; if (vld_w !== 1'b1) $display("FAIL req_cancel_ignored got %0b want 1", vld_w); else n_pass++;
    n_total++; if (en_w !== 1'b1) $display("FAIL req_en_held got %0b want 1", en_w); else n_pass++;
    @(negedge clk);
    move_ready = 1'b1;
    n_total++; if (vld_w !== 1'b1) $display("FAIL req_before_hs got %0b want 1", vld_w); else n_pass++;
    @(negedge clk);
    move_ready = 1'b0;
    n_total++; if (vld_w !== 1'b0) $display("FAIL hs_valid got %0b want 0", vld_w); else n_pass++;
    n_total++; if (en_w !== 1'b0) $display("FAIL hs_en got %0b want 0", en_w); else n_pass++;
    press(B_CENTER);
    n_total++; if (en_w !== 1'b0 || vld_w !== 1'b0) $display("FAIL post_hs_idle got en=%0b vld=%0b want 0 0", en_w, vld_w); else n_pass++;
  endtask

  task automatic test_no_select();
    do_reset();
    for (int i = 0; i < 6; i++) press(B_UP);
    n_total++; if (cur_w !== 6'd12) $display("FAIL nosel_cursor got %0d want 12", cur_w); else n_pass++;
    press(B_CENTER);
    n_total++; if (en_w !== 1'b0) $display("FAIL nosel_black got %0b want 0", en_w); else n_pass++;
    for (int i = 0; i < 3; i++) press(B_DOWN);
    press(B_CENTER);
    n_total++; if (en_w !== 1'b0 || vld_w !== 1'b0) $display("FAIL nosel_empty got en=%0b vld=%0b want 0 0", en_w, vld_w); else n_pass++;
    n_total++; if (cur_w !== 6'd36) $display("FAIL nosel_cursor36 got %0d want 36", cur_w); else n_pass++;
  endtask

  task automatic test_reselect();
    do_reset();
    press(B_UP);
    press(B_CENTER);
    press(B_LEFT);
    press(B_CENTER);
    n_total++; if (sel_w !== 6'd51) $display("FAIL resel_addr got %0d want 51", sel_w); else n_pass++;
    n_total++; if (en_w !== 1'b1 || vld_w !== 1'b0) $display("FAIL resel_state got en=%0b vld=%0b want 1 0", en_w, vld_w); else n_pass++;
    press(B_CENTER);
    n_total++; if (en_w !== 1'b0) $display("FAIL deselect got %0b want 0", en_w); else n_pass++;
    n_total++; if (sel_w !== 6'd51) $display("FAIL deselect_addr_kept got %0d want 51", sel_w); else n_pass++;
  endtask

  task automatic test_cancel_priority();
    do_reset();
    press(B_UP);
    press(B_CENTER);
    press(B_CANCEL | B_CENTER);
    n_total++; if (en_w !== 1'b0 || vld_w !== 1'b0) $display("FAIL cancel_center got en=%0b vld=%0b want 0 0", en_w, vld_w); else n_pass++;
    press(B_CENTER | B_UP);
    n_total++; if (en_w !== 1'b1 || cur_w !== 6'd52) $display("FAIL center_over_dir got en=%0b cur=%0d want 1 52", en_w, cur_w); else n_pass++;
    press(B_CANCEL | B_UP);
    n_total++; if (en_w !== 1'b0 || cur_w !== 6'd52) $display("FAIL cancel_over_dir got en=%0b cur=%0d want 0 52", en_w, cur_w); else n_pass++;
  endtask

  task automatic test_stale();
    do_reset();
    press(B_UP);
    press(B_CENTER);
    @(negedge clk);
    turn = 1'b1;
    @(negedge clk);
    turn = 1'b0;
    n_total++; if (en_w !== 1'b0) $display("FAIL stale_turn got %0b want 0", en_w); else n_pass++;
    press(B_CENTER);
    @(negedge clk);
    board[4*52 +: 4] = 4'h0;
    @(negedge clk);
    load_start_board();
    n_total++; if (en_w !== 1'b0) $display("FAIL stale_board got %0b want 0", en_w); else n_pass++;
  endtask

  task automatic test_rst_in_request();
    do_reset();
    press(B_UP);
    press(B_CENTER);
    press(B_UP);
    press(B_UP);
    press(B_CENTER);
    n_total++; if (vld_w !== 1'b1) $display("FAIL rstreq_pre got %0b want 1", vld_w); else n_pass++;
    do_reset();
    n_total++; if (vld_w !== 1'b0 || en_w !== 1'b0) $display("FAIL rstreq_ctrl got vld=%0b en=%0b want 0 0", vld_w, en_w); else n_pass++;
    n_total++; if (cur_w !== 6'd60 || sel_w !== 6'd0) $display("FAIL rstreq_addr got cur=%0d sel=%0d want 60 0", cur_w, sel_w); else n_pass++;
    n_total++; if (from_w !== 6'd0 || to_w !== 6'd0) $display("FAIL rstreq_move got from=%0d to=%0d want 0 0", from_w, to_w); else n_pass++;
  endtask

  initial begin
    load_start_board();
    test_reset();
    test_cursor();
    test_move_request();
    test_no_select();
    test_reselect();
    test_cancel_priority();
    test_stale();
    test_rst_in_request();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
